accel_host_driver: RTL and testbench
====================================

Name: accel_host_driver

Overview:
- Host-side initiator for the accelerator's host port.
- Accepts a valid/ready beat stream, writes the first i_w_words beats into the weight scratchpad and the next i_i_words beats into the input scratchpad, then raises route enable.
- Captures every o_ofmap/o_ofmap_valid result into an output FIFO and presents the results as a valid/ready stream.
- Completion is reported once the accelerator signals done and the FIFO has drained.

Parameters:
DATA_WIDTH, 8, activation/weight element width; result width is 2*DATA_WIDTH
SPAD_DATA_WIDTH, 64, scratchpad write word width
ADDR_WIDTH, 8, scratchpad address width and word-count width
OUT_FIFO_DEPTH, 16, result FIFO entries (power of two, >=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  one-cycle job start; ignored unless idle
i_w_base  in  ADDR_WIDTH  first weight scratchpad address
i_w_words  in  ADDR_WIDTH  weight beats to load (0 = skip)
i_i_base  in  ADDR_WIDTH  first input scratchpad address
i_i_words  in  ADDR_WIDTH  input beats to load (0 = skip)
i_s_data  in  SPAD_DATA_WIDTH  load stream data
i_s_valid  in  1  load stream valid
o_s_ready  out  1  load stream ready
o_data_in  out  SPAD_DATA_WIDTH  scratchpad write data to accelerator
o_write_addr  out  ADDR_WIDTH  scratchpad write address
o_spad_select  out  1  0 = weight scratchpad, 1 = input scratchpad
o_write_en  out  1  scratchpad write strobe
o_route_en  out  1  route enable to accelerator
i_ofmap  in  2*DATA_WIDTH  accelerator result
i_ofmap_valid  in  1  result valid (no backpressure)
i_done  in  1  accelerator job done
o_m_data  out  2*DATA_WIDTH  result stream data
o_m_valid  out  1  result stream valid
i_m_ready  in  1  result stream ready
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle job-complete pulse
o_overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (i_rst sampled high at a clock edge): state IDLE; FIFO empty; all outputs 0, including o_write_addr, o_data_in and o_overflow.
- Bases and word counts are latched when i_start is accepted. Inputs changing mid-job have no effect.
- State machine: IDLE -> LOAD_W -> LOAD_I -> ROUTE -> DRAIN -> FIN -> IDLE.
- IDLE -> LOAD_W on i_start.
  - LOAD_W is skipped when the latched weight count is 0.
  - LOAD_I is skipped when the latched input count is 0.
  - If both counts are 0, go straight to ROUTE.
- o_s_ready is high only in LOAD_W/LOAD_I. A beat is accepted when i_s_valid && o_s_ready.
- Write timing: an accepted beat produces, on the next cycle, a one-cycle registered write with:
  - o_write_en = 1;
  - o_data_in = the beat;
  - o_write_addr = base + beat index, modulo 2^ADDR_WIDTH (wrap permitted, silent);
  - o_spad_select = 0 in LOAD_W, 1 in LOAD_I.
- Counts and back-to-back behaviour:
  - The beat counter resets to 0 on each load-state entry.
  - Acceptance of the final beat of a state transitions the state immediately.
  - Back-to-back beats give one write per cycle at full throughput.
  - o_spad_select holds its last value while no write is pending.
- ROUTE:
  - o_route_en rises on the cycle after the last input write, or one cycle after entry if nothing was loaded.
  - It is held high until i_done is sampled, then deasserts on the same edge the state goes to DRAIN.
- Result capture: results are captured only in ROUTE.
  - Each i_ofmap_valid pushes i_ofmap into the FIFO.
  - If the FIFO is full and no pop happens the same cycle, the result is dropped and o_overflow sets (cleared only by reset or the next accepted i_start).
  - A push and a pop in the same cycle on a full FIFO are both accepted.
  - A result arriving in the same cycle as i_done is still captured.
- Result stream: o_m_valid = FIFO not empty and o_m_data = FIFO head, both combinational from FIFO state. A pop occurs when o_m_valid && i_m_ready. Per AXI-style rules, data stays stable while valid is high and ready is low.
- DRAIN -> FIN once the FIFO is empty. FIN asserts o_done for exactly one cycle, then goes to IDLE.
- i_start is ignored outside IDLE. i_done outside ROUTE is ignored.
- Reset mid-job: the job aborts; the FIFO contents and any pending write are discarded; o_write_en and o_route_en are 0 on the next cycle.

Decomposition:
- Package accel_host_pkg: the state enum (IDLE, LOAD_W, LOAD_I, ROUTE, DRAIN, FIN) and the SPAD_SEL_W = 0 / SPAD_SEL_I = 1 constants.
- One sub-module, sync_fifo (width and depth parameters, push/pop/full/empty/count, synchronous active-high reset), used for the result FIFO.
- The FSM, counters and write register live in accel_host_driver.

Test Plan:
- Basic load: w_base=0x10, w_words=3, i_base=0xF0, i_words=2, stream with valid held high -> writes at 0x10,0x11,0x12 with select 0, then 0xF0,0xF1 with select 1, one per cycle, each one cycle after acceptance; route_en is high on the following cycle.
- Wrap and stalls: i_base=0xFE, i_words=4, valid toggled 1-0-1-0 -> addresses 0xFE,0xFF,0x00,0x01, no write in stall cycles, o_s_ready=0 after the 4th beat.
- Zero counts: w_words=0, i_words=0 -> no o_write_en; route_en high one cycle after start; i_done -> o_done pulses once FIFO empty.
- Result path: 5 results then i_done, i_m_ready held low then released -> o_m_data emits the 5 values in order, o_done pulses only after the last pop.
- Overflow: DEPTH=16, 18 results with i_m_ready=0 -> first 16 retained, o_overflow=1; next i_start clears it.
- Mid-job reset: i_rst asserted in LOAD_I -> next cycle o_busy=0, o_write_en=0, o_route_en=0, o_m_valid=0.

Source files
------------

// File: rtl/accel_host_pkg.sv
// Shared types for the accelerator host driver.
// FSM state encoding and scratchpad select values.
package accel_host_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_I = 3'd2,
    ROUTE  = 3'd3,
    DRAIN  = 3'd4,
    FIN    = 3'd5
  } state_t;

  localparam logic SPAD_SEL_W = 1'b0;
  localparam logic SPAD_SEL_I = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and a combinational head.
// Push on full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so the output is clean after reset
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/accel_host_driver.sv
// Host-side initiator: streams weights/inputs into the scratchpads,
// routes the job, and buffers results into an output stream.
module accel_host_driver
  import accel_host_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int SPAD_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int OUT_FIFO_DEPTH  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [ADDR_WIDTH-1:0]      i_w_base,
  input  logic [ADDR_WIDTH-1:0]      i_w_words,
  input  logic [ADDR_WIDTH-1:0]      i_i_base,
  input  logic [ADDR_WIDTH-1:0]      i_i_words,
  input  logic [SPAD_DATA_WIDTH-1:0] i_s_data,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  output logic [SPAD_DATA_WIDTH-1:0] o_data_in,
  output logic [ADDR_WIDTH-1:0]      o_write_addr,
  output logic                       o_spad_select,
  output logic                       o_write_en,
  output logic                       o_route_en,
  input  logic [2*DATA_WIDTH-1:0]    i_ofmap,
  input  logic                       i_ofmap_valid,
  input  logic                       i_done,
  output logic [2*DATA_WIDTH-1:0]    o_m_data,
  output logic                       o_m_valid,
  input  logic                       i_m_ready,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow
);

  localparam int FAW = $clog2(OUT_FIFO_DEPTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_words;
  logic [ADDR_WIDTH-1:0] i_base;
  logic [ADDR_WIDTH-1:0] i_words;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic                  accept;
  logic                  last_w;
  logic                  last_i;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FAW:0]          fifo_count;

  assign o_s_ready = (state == LOAD_W) || (state == LOAD_I);
  assign accept    = i_s_valid && o_s_ready;
  assign last_w    = (beat_cnt == w_words - 1'b1);
  assign last_i    = (beat_cnt == i_words - 1'b1);
  assign o_busy    = (state != IDLE);
  assign o_done    = (state == FIN);
  assign o_m_valid = !fifo_empty;
  assign push      = (state == ROUTE) && i_ofmap_valid;
  assign pop       = o_m_valid && i_m_ready;

  sync_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .push    (push),
    .pop     (pop),
    .wr_data (i_ofmap),
    .rd_data (o_m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      w_base        <= '0;
      w_words       <= '0;
      i_base        <= '0;
      i_words       <= '0;
      beat_cnt      <= '0;
      o_write_en    <= 1'b0;
      o_write_addr  <= '0;
      o_data_in     <= '0;
      o_spad_select <= SPAD_SEL_W;
      o_route_en    <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_write_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            w_base     <= i_w_base;
            w_words    <= i_w_words;
            i_base     <= i_i_base;
            i_words    <= i_i_words;
            beat_cnt   <= '0;
            o_overflow <= 1'b0;
            if (i_w_words != '0)      state <= LOAD_W;
            else if (i_i_words != '0) state <= LOAD_I;
            else                      state <= ROUTE;
          end
        end
        LOAD_W: begin
          if (accept) begin
            o_write_en    <= 1'b1;
            o_write_addr  <= w_base + beat_cnt;
            o_data_in     <= i_s_data;
            o_spad_select <= SPAD_SEL_W;
            if (last_w) begin
              beat_cnt <= '0;
              state    <= (i_words != '0) ? LOAD_I : ROUTE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        LOAD_I: begin
          if (accept) begin
            o_write_en    <= 1'b1;
            o_write_addr  <= i_base + beat_cnt;
            o_data_in     <= i_s_data;
            o_spad_select <= SPAD_SEL_I;
            if (last_i) begin
              beat_cnt <= '0;
              state    <= ROUTE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ROUTE: begin
          if (i_done) begin
            o_route_en <= 1'b0;
            state      <= DRAIN;
          end else begin
            o_route_en <= 1'b1;
          end
        end
        DRAIN: begin
          if (fifo_count == '0) state <= FIN;
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
      // A result is lost only when full and nothing frees a slot this cycle
      if (push && fifo_full && !pop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accel_host_driver.sv
// Scoreboard bench for accel_host_driver.
// Expected writes/results are queued at stimulus time and popped by monitors.
module tb_accel_host_driver;

  typedef struct packed {
    int          cyc;
    logic        sel;
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  w_base, w_words, i_base, i_words;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] data_in;
  logic [7:0]  write_addr;
  logic        spad_select;
  logic        write_en;
  logic        route_en;
  logic [15:0] ofmap;
  logic        ofmap_valid;
  logic        done_in;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  wr_t         wq[$];
  logic [15:0] rq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  accel_host_driver dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_w_base      (w_base),
    .i_w_words     (w_words),
    .i_i_base      (i_base),
    .i_i_words     (i_words),
    .i_s_data      (s_data),
    .i_s_valid     (s_valid),
    .o_s_ready     (s_ready),
    .o_data_in     (data_in),
    .o_write_addr  (write_addr),
    .o_spad_select (spad_select),
    .o_write_en    (write_en),
    .o_route_en    (route_en),
    .i_ofmap       (ofmap),
    .i_ofmap_valid (ofmap_valid),
    .i_done        (done_in),
    .o_m_data      (m_data),
    .o_m_valid     (m_valid),
    .i_m_ready     (m_ready),
    .o_busy        (busy),
    .o_done        (done),
    .o_overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", {56'd0, write_addr}, 64'hFFFF);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", {56'd0, write_addr}, {56'd0, e.addr});
        chk("wr_sel", {63'd0, spad_select}, {63'd0, e.sel});
        chk("wr_data", data_in, e.data);
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      if (rq.size() == 0) begin
        chk("unexpected_result", {48'd0, m_data}, 64'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = rq.pop_front();
        chk("result", {48'd0, m_data}, {48'd0, e});
      end
    end
  end

  task automatic start_job(input logic [7:0] wb, input logic [7:0] ww,
                           input logic [7:0] ib, input logic [7:0] iw);
    w_base  = wb;
    w_words = ww;
    i_base  = ib;
    i_words = iw;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    // Scramble job inputs to prove they were latched
    w_base  = ~wb;
    w_words = 8'd7;
    i_base  = ~ib;
    i_words = 8'd9;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic sel,
                           input logic [7:0] addr);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        wq.push_back('{cyc: cyc, sel: sel, addr: addr, data: d});
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    if (!ok) chk("beat_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_done();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk("done_after_drain", 64'(rq.size()), 64'd0);
        break;
      end
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    w_base = '0; w_words = '0; i_base = '0; i_words = '0;
    s_data = '0; s_valid = 1'b0;
    ofmap = '0; ofmap_valid = 1'b0; done_in = 1'b0; m_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_write_en", {63'd0, write_en}, 64'd0);
    chk("rst_route_en", {63'd0, route_en}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_addr_data", {data_in[55:0], write_addr}, 64'd0);
    chk("rst_m_data", {48'd0, m_data}, 64'd0);

    // Basic back-to-back load
    start_job(8'h10, 8'd3, 8'hF0, 8'd2);
    for (int k = 0; k < 3; k++)
      send_beat(64'hA0A0_0000_0000_0000 | 64'(k), 1'b0, 8'(8'h10 + k));
    for (int k = 0; k < 2; k++)
      send_beat(64'hB0B0_0000_0000_0000 | 64'(k), 1'b1, 8'(8'hF0 + k));
    chk("b_s_ready_off", {63'd0, s_ready}, 64'd0);
    chk("b_route_pre", {63'd0, route_en}, 64'd0);
    tick();
    chk("b_route_on", {63'd0, route_en}, 64'd1);
    pulse_done();
    chk("b_route_off", {63'd0, route_en}, 64'd0);
    wait_done();

    // Wrap-around with stalls between beats
    start_job(8'h33, 8'd0, 8'hFE, 8'd4);
    for (int k = 0; k < 4; k++) begin
      send_beat(64'hC0C0_0000_0000_0000 | 64'(k), 1'b1, 8'(8'hFE + k));
      if (k < 3) tick();
    end
    chk("w_s_ready_off", {63'd0, s_ready}, 64'd0);
    tick();
    pulse_done();
    wait_done();

    // Zero counts: straight to ROUTE
    start_job(8'h01, 8'd0, 8'h02, 8'd0);
    chk("z_busy", {63'd0, busy}, 64'd1);
    chk("z_route_pre", {63'd0, route_en}, 64'd0);
    tick();
    chk("z_route_on", {63'd0, route_en}, 64'd1);
    pulse_done();
    wait_done();

    // Result path with downstream backpressure
    m_ready = 1'b0;
    start_job(8'h00, 8'd0, 8'h00, 8'd0);
    for (int k = 0; k < 5; k++) begin
      ofmap       = 16'h1230 + 16'(k);
      ofmap_valid = 1'b1;
      rq.push_back(ofmap);
      tick();
    end
    ofmap_valid = 1'b0;
    pulse_done();
    tick();
    tick();
    chk("r_no_done_early", {63'd0, done}, 64'd0);
    chk("r_m_valid", {63'd0, m_valid}, 64'd1);
    chk("r_head_stable", {48'd0, m_data}, {48'd0, rq[0]});
    m_ready = 1'b1;
    wait_done();

    // Overflow: 18 results into a 16-deep FIFO
    m_ready = 1'b0;
    start_job(8'h00, 8'd0, 8'h00, 8'd0);
    for (int k = 0; k < 18; k++) begin
      ofmap       = 16'h5500 + 16'(k);
      ofmap_valid = 1'b1;
      if (k < 16) rq.push_back(ofmap);
      if (k == 15) begin
        @(negedge clk);
        chk("o_no_ovf_at_16", {63'd0, overflow}, 64'd0);
      end
      tick();
    end
    ofmap_valid = 1'b0;
    chk("o_overflow_set", {63'd0, overflow}, 64'd1);
    pulse_done();
    m_ready = 1'b1;
    wait_done();
    chk("o_overflow_sticky", {63'd0, overflow}, 64'd1);
    start_job(8'h00, 8'd0, 8'h00, 8'd0);
    chk("o_overflow_clear", {63'd0, overflow}, 64'd0);
    tick();
    pulse_done();
    wait_done();

    // Reset while loading inputs, with a beat offered at the reset edge
    start_job(8'h20, 8'd1, 8'h40, 8'd3);
    send_beat(64'hD0D0_0000_0000_0001, 1'b0, 8'h20);
    send_beat(64'hE0E0_0000_0000_0002, 1'b1, 8'h40);
    s_valid = 1'b1;
    s_data  = 64'hDEAD_BEEF_0000_0003;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    s_valid = 1'b0;
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_write_en", {63'd0, write_en}, 64'd0);
    chk("mr_route_en", {63'd0, route_en}, 64'd0);
    chk("mr_m_valid", {63'd0, m_valid}, 64'd0);
    tick();
    tick();
    chk("writes_drained", 64'(wq.size()), 64'd0);
    chk("results_drained", 64'(rq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
